// File: rtl/vcxo_lock_monitor.sv
// vcxo_lock_monitor
//
// Receive-side companion of the VCXO discipline loop, in the system clock
// domain. It does three things:
//   - Captures each frequency-error/PWM measurement that the VCXO-domain
//     controller announces by toggling sample_tgl.
//   - Runs lock/unlock detection with hysteresis on the captured error.
//   - Serialises a fixed status frame to the MCU byte link.
//
// Frame layout: A5, status {locked, lost_sticky, overrun, 5'b0},
//   fe[23:16], fe[15:8], fe[7:0], pwm[15:8], pwm[7:0]
//   and, with VCXO_MON_CHECKSUM_EN defined, an XOR checksum of bytes 1..6.
//
// Build option:
//   VCXO_MON_CHECKSUM_EN  when defined, the frame is 8 bytes with the checksum
//                         byte appended. When not defined, the frame is 7 bytes.
//
// Ports:
//   clk_in       in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   sample_tgl   in   1  toggles once per measurement (foreign domain)
//   freq_error   in  24  signed frequency error, 100 Hz units
//   pwm          in  16  signed pump duty word
//   clr_lost     in   1  single-cycle clear of lost_sticky
//   tx_ready     in   1  MCU link accepts the current byte
//   tx_data      out  8  frame byte
//   tx_valid     out  1  tx_data valid
//   locked       out  1  lock status
//   lost_sticky  out  1  lock dropped since last clear
//   overrun      out  1  sample arrived while a frame was pending
module vcxo_lock_monitor #(
  parameter int LOCK_TOL     = 20,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        sample_tgl,
  input  logic [23:0] freq_error,
  input  logic [15:0] pwm,
  input  logic        clr_lost,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        locked,
  output logic        lost_sticky,
  output logic        overrun
);

`ifdef VCXO_MON_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif
  localparam logic [24:0] TOL      = 25'(LOCK_TOL);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0]  UNLOCK_N = 8'(UNLOCK_COUNT);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} frame_state_t;

  logic [2:0]   sync_q;
  logic [1:0]   warm_q;
  logic         cap_pulse;
  logic [23:0]  snap_fe;
  logic [15:0]  snap_pwm;
  logic [24:0]  fe_ext;
  logic [24:0]  fe_abs;
  logic         in_window;
  lock_state_t  lock_q, lock_d;
  logic [7:0]   in_cnt_q, in_cnt_d;
  logic [7:0]   out_cnt_q, out_cnt_d;
  logic         lost_set;
  frame_state_t frame_q, frame_d;
  logic [2:0]   idx_q, idx_d;
  logic [2:0]   buf_stat;
  logic [23:0]  buf_fe;
  logic [15:0]  buf_pwm;

  // warm_q masks the capture pulse until all three synchroniser flops hold
  // the live toggle level after reset. Otherwise a toggle line that sits at 1
  // through reset would look like a fresh measurement.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sample_tgl};
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign cap_pulse = (warm_q == 2'd3) && (sync_q[2] != sync_q[1]);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      snap_fe  <= '0;
      snap_pwm <= '0;
    end else if (cap_pulse) begin
      snap_fe  <= freq_error;
      snap_pwm <= pwm;
    end
  end

  // freq_error is held stable around the toggle, so the window test can use
  // the live input on the capture cycle. A 25-bit magnitude keeps -2^23
  // representable, so that value tests as out-of-window.
  assign fe_ext    = {freq_error[23], freq_error};
  assign fe_abs    = fe_ext[24] ? (25'd0 - fe_ext) : fe_ext;
  assign in_window = (fe_abs <= TOL);

  always_comb begin
    lock_d    = lock_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    lost_set  = 1'b0;
    if (cap_pulse) begin
      case (lock_q)
        UNLOCKED: begin
          if (!in_window) begin
            in_cnt_d = '0;
          end else if (in_cnt_q + 8'd1 == LOCK_N) begin
            lock_d    = LOCKED;
            in_cnt_d  = '0;
            out_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          if (in_window) begin
            out_cnt_d = '0;
          end else if (out_cnt_q + 8'd1 == UNLOCK_N) begin
            lock_d    = UNLOCKED;
            out_cnt_d = '0;
            in_cnt_d  = '0;
            lost_set  = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + 8'd1;
          end
        end
        default: lock_d = UNLOCKED;
      endcase
    end
  end

  // A set of lost_sticky takes priority over a clear in the same cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= UNLOCKED;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      lost_sticky <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (lost_set)      lost_sticky <= 1'b1;
      else if (clr_lost) lost_sticky <= 1'b0;
    end
  end

  assign locked = (lock_q == LOCKED);

  // A capture during LOAD/SEND is reported as overrun, not queued. The set
  // takes priority over the clear that LOAD performs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (cap_pulse && (frame_q != IDLE)) begin
      overrun <= 1'b1;
    end else if (frame_q == LOAD) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= IDLE;
      idx_q    <= '0;
      buf_stat <= '0;
      buf_fe   <= '0;
      buf_pwm  <= '0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      if (frame_q == LOAD) begin
        buf_stat <= {locked, lost_sticky, overrun};
        buf_fe   <= snap_fe;
        buf_pwm  <= snap_pwm;
      end
    end
  end

`ifdef VCXO_MON_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = {buf_stat, 5'b0} ^ buf_fe[23:16] ^ buf_fe[15:8] ^
                    buf_fe[7:0] ^ buf_pwm[15:8] ^ buf_pwm[7:0];
`endif

  always_comb begin
    frame_d  = frame_q;
    idx_d    = idx_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (frame_q)
      IDLE: if (cap_pulse) frame_d = LOAD;
      LOAD: begin
        frame_d = SEND;
        idx_d   = '0;
      end
      SEND: begin
        tx_valid = 1'b1;
        case (idx_q)
          3'd0:    tx_data = 8'hA5;
          3'd1:    tx_data = {buf_stat, 5'b0};
          3'd2:    tx_data = buf_fe[23:16];
          3'd3:    tx_data = buf_fe[15:8];
          3'd4:    tx_data = buf_fe[7:0];
          3'd5:    tx_data = buf_pwm[15:8];
          3'd6:    tx_data = buf_pwm[7:0];
`ifdef VCXO_MON_CHECKSUM_EN
          3'd7:    tx_data = checksum;
`endif
          default: tx_data = 8'h00;
        endcase
        if (tx_ready) begin
          if (idx_q == LAST_IDX) frame_d = IDLE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      default: frame_d = IDLE;
    endcase
  end

endmodule
